// File: rtl/db15_joy_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | db15_joy_responder                                                       |
// | Device side of the DB15 serial joystick link: two cascaded PISO stages   |
// | answering host JOY_LOAD/JOY_CLK with both players' buttons on JOY_DATA.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

// Two-flop synchronizer followed by a consecutive-sample glitch filter.
// The accepted level flips on the (FILTER+1)-th consecutive disagreeing sample.
module db15_strobe_sync_filter #(
    parameter int   FILTER = 2,
    parameter logic IDLE   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic strobe_i,
    output logic level_q_o,
    output logic level_d_o
);

    localparam int CW = $clog2(FILTER + 1);
    localparam logic [CW-1:0] C_FILT = CW'(FILTER);

    logic [1:0]    sync_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= {2{IDLE}};
            level_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], strobe_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == C_FILT) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign level_q_o = level_q;
    assign level_d_o = level_d;

endmodule

module db15_joy_responder #(
    parameter int BITS   = 16,
    parameter int FILTER = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [BITS-1:0]                   joystick1,
    input  logic [BITS-1:0]                   joystick2,
    input  logic                              JOY_LOAD,
    input  logic                              JOY_CLK,
    output logic                              JOY_DATA,
    output logic [$clog2(2*BITS+1)-1:0]       bit_cnt,
    output logic                              frame_done,
    output logic                              short_frame
);

    localparam int FRAME = 2 * BITS;
    localparam int CNTW  = $clog2(FRAME + 1);
    localparam logic [CNTW-1:0] C_FULL = CNTW'(FRAME);
    localparam logic [CNTW-1:0] C_LAST = CNTW'(FRAME - 1);

    logic load_lvl_q;
    logic load_lvl_d;
    logic clk_lvl_q;
    logic clk_lvl_d;

    db15_strobe_sync_filter #(
        .FILTER (FILTER),
        .IDLE   (1'b1)
    ) u_load_filter (
        .clk       (clk),
        .reset     (reset),
        .strobe_i  (JOY_LOAD),
        .level_q_o (load_lvl_q),
        .level_d_o (load_lvl_d)
    );

    db15_strobe_sync_filter #(
        .FILTER (FILTER),
        .IDLE   (1'b0)
    ) u_clk_filter (
        .clk       (clk),
        .reset     (reset),
        .strobe_i  (JOY_CLK),
        .level_q_o (clk_lvl_q),
        .level_d_o (clk_lvl_d)
    );

    // Act on the filter's next level so the strobe takes effect the same
    // cycle it is accepted; edges are judged against the accepted level only.
    logic w_load_active;
    logic w_load_fall;
    logic w_shift;

    assign w_load_active = ~load_lvl_d;
    assign w_load_fall   = load_lvl_q & ~load_lvl_d;
    assign w_shift       = ~clk_lvl_q & clk_lvl_d & load_lvl_d;

    logic [FRAME-1:0] sr_q;
    logic [FRAME-1:0] sr_d;
    logic [CNTW-1:0]  cnt_q;
    logic [CNTW-1:0]  cnt_d;
    logic             frame_done_q;
    logic             frame_done_d;
    logic             short_frame_q;
    logic             short_frame_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q          <= '1;
            cnt_q         <= '0;
            frame_done_q  <= 1'b0;
            short_frame_q <= 1'b0;
        end else begin
            sr_q          <= sr_d;
            cnt_q         <= cnt_d;
            frame_done_q  <= frame_done_d;
            short_frame_q <= short_frame_d;
        end
    end

    always_comb begin
        sr_d          = sr_q;
        cnt_d         = cnt_q;
        frame_done_d  = 1'b0;
        short_frame_d = 1'b0;
        if (w_load_active) begin
            // Transparent while loading: the snapshot is whatever was loaded last.
            sr_d          = {~joystick2, ~joystick1};
            cnt_d         = '0;
            short_frame_d = w_load_fall && (cnt_q != '0) && (cnt_q < C_FULL);
        end else if (w_shift) begin
            sr_d = {1'b1, sr_q[FRAME-1:1]};
            if (cnt_q < C_FULL) begin
                cnt_d        = cnt_q + CNTW'(1);
                frame_done_d = (cnt_q == C_LAST);
            end
        end
    end

    assign JOY_DATA    = sr_q[0];
    assign bit_cnt     = cnt_q;
    assign frame_done  = frame_done_q;
    assign short_frame = short_frame_q;

endmodule
`default_nettype wire

// File: tb/tb_db15_joy_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_db15_joy_responder                                                    |
// | Self-checking bench for the DB15 joystick responder.                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_db15_joy_responder;

    localparam int BITS   = 16;
    localparam int FILTER = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] joystick1 = 16'h0000;
    logic [15:0] joystick2 = 16'h0000;
    logic        JOY_LOAD = 1'b1;
    logic        JOY_CLK = 1'b0;
    logic        JOY_DATA;
    logic [5:0]  bit_cnt;
    logic        frame_done;
    logic        short_frame;

    db15_joy_responder #(
        .BITS   (BITS),
        .FILTER (FILTER)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .joystick1   (joystick1),
        .joystick2   (joystick2),
        .JOY_LOAD    (JOY_LOAD),
        .JOY_CLK     (JOY_CLK),
        .JOY_DATA    (JOY_DATA),
        .bit_cnt     (bit_cnt),
        .frame_done  (frame_done),
        .short_frame (short_frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       d;
        logic [5:0] c;
    } exp_t;

    typedef struct {
        logic [15:0] j1;
        logic        exp_d;
    } vec_t;

    exp_t        sbq[$];
    vec_t        vtab[6];
    int          total = 0;
    int          bad = 0;
    int          fd_cnt = 0;
    int          sf_cnt = 0;
    int          fd0;
    int          sf0;
    logic [31:0] frm;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
        if (short_frame === 1'b1) sf_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation bound expired");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [31:0] f, input int k);
        if (k < 32) return f[k];
        return 1'b1;
    endfunction

    task automatic do_load(input int n);
        JOY_LOAD = 1'b0;
        tick(n);
        JOY_LOAD = 1'b1;
        tick(10);
    endtask

    // One host clock period; the expected post-shift state is queued at the rise.
    task automatic clock_edge(input logic ed, input logic [5:0] ec);
        exp_t e;
        e.d = ed;
        e.c = ec;
        sbq.push_back(e);
        JOY_CLK = 1'b1;
        tick(10);
        if (sbq.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            check("shift_data", {31'd0, JOY_DATA}, {31'd0, e.d});
            check("shift_cnt", {26'd0, bit_cnt}, {26'd0, e.c});
        end
        JOY_CLK = 1'b0;
        tick(10);
    endtask

    initial begin
        vtab[0] = '{16'h0000, 1'b1};
        vtab[1] = '{16'h0001, 1'b0};
        vtab[2] = '{16'hFFFE, 1'b1};
        vtab[3] = '{16'h0003, 1'b0};
        vtab[4] = '{16'h8000, 1'b1};
        vtab[5] = '{16'h7FFF, 1'b0};

        // Reset state
        tick(3);
        check("rst_data", {31'd0, JOY_DATA}, 32'd1);
        check("rst_cnt", {26'd0, bit_cnt}, 32'd0);
        check("rst_fd", {31'd0, frame_done}, 32'd0);
        check("rst_sf", {31'd0, short_frame}, 32'd0);
        reset = 1'b0;
        tick(2);

        // Full frame
        joystick1 = 16'h0005;
        joystick2 = 16'h8000;
        frm = {~joystick2, ~joystick1};
        sf0 = sf_cnt;
        do_load(10);
        check("ff_first_bit", {31'd0, JOY_DATA}, 32'd0);
        check("ff_cnt0", {26'd0, bit_cnt}, 32'd0);
        check("ff_no_sf", sf_cnt - sf0, 0);
        fd0 = fd_cnt;
        for (int r = 0; r < 32; r++) begin
            clock_edge(exp_bit(frm, r + 1), 6'(r + 1));
            if (r == 30) check("ff_fd_early", fd_cnt - fd0, 0);
        end
        check("ff_fd_once", fd_cnt - fd0, 1);
        clock_edge(1'b1, 6'd32);
        check("ff_fd_sat", fd_cnt - fd0, 1);

        // Freeze: inputs change mid-frame, frame keeps the snapshot
        joystick1 = 16'hA5C3;
        joystick2 = 16'h1234;
        frm = {~joystick2, ~joystick1};
        sf0 = sf_cnt;
        do_load(10);
        check("fz_no_sf_full", sf_cnt - sf0, 0);
        check("fz_first_bit", {31'd0, JOY_DATA}, {31'd0, frm[0]});
        fd0 = fd_cnt;
        for (int r = 0; r < 32; r++) begin
            if (r == 10) begin
                joystick1 = 16'hFFFF;
                joystick2 = 16'h0000;
            end
            clock_edge(exp_bit(frm, r + 1), 6'(r + 1));
        end
        check("fz_fd_once", fd_cnt - fd0, 1);

        // Short frame, including latency boundary of the load
        joystick1 = 16'h0003;
        joystick2 = 16'h0000;
        frm = {~joystick2, ~joystick1};
        do_load(10);
        for (int r = 0; r < 7; r++) clock_edge(exp_bit(frm, r + 1), 6'(r + 1));
        sf0 = sf_cnt;
        JOY_LOAD = 1'b0;
        tick(4);
        check("sf_lat_cnt", {26'd0, bit_cnt}, 32'd7);
        check("sf_lat_pulse", {31'd0, short_frame}, 32'd0);
        tick(1);
        check("sf_pulse", {31'd0, short_frame}, 32'd1);
        check("sf_cnt0", {26'd0, bit_cnt}, 32'd0);
        check("sf_data", {31'd0, JOY_DATA}, 32'd0);
        tick(9);
        check("sf_once", sf_cnt - sf0, 1);

        // Load priority: clocks while load held low
        for (int i = 0; i < 5; i++) begin
            JOY_CLK = 1'b1;
            tick(10);
            JOY_CLK = 1'b0;
            tick(10);
        end
        check("lp_cnt", {26'd0, bit_cnt}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            exp_t e;
            joystick1 = vtab[i].j1;
            e.d = vtab[i].exp_d;
            e.c = 6'd0;
            sbq.push_back(e);
            tick(1);
            e = sbq.pop_front();
            check("live_data", {31'd0, JOY_DATA}, {31'd0, e.d});
            check("live_cnt", {26'd0, bit_cnt}, {26'd0, e.c});
        end
        check("lp_sf_once", sf_cnt - sf0, 1);

        // Glitch rejection
        joystick1 = 16'h0002;
        frm = {16'hFFFF, ~joystick1};
        tick(1);
        JOY_LOAD = 1'b1;
        tick(10);
        for (int w = 1; w <= 2; w++) begin
            JOY_CLK = 1'b1;
            tick(w);
            JOY_CLK = 1'b0;
            tick(10);
            check("gl_cnt", {26'd0, bit_cnt}, 32'd0);
            check("gl_data", {31'd0, JOY_DATA}, 32'd1);
        end
        JOY_CLK = 1'b1;
        tick(4);
        JOY_CLK = 1'b0;
        tick(10);
        check("gl4_cnt", {26'd0, bit_cnt}, 32'd1);
        check("gl4_data", {31'd0, JOY_DATA}, 32'd0);
        JOY_CLK = 1'b1;
        tick(4);
        check("clk_lat_before", {26'd0, bit_cnt}, 32'd1);
        tick(1);
        check("clk_lat_after", {26'd0, bit_cnt}, 32'd2);
        tick(5);
        JOY_CLK = 1'b0;
        tick(10);

        // Reset mid-frame at bit 10
        for (int r = 2; r < 10; r++) clock_edge(exp_bit(frm, r + 1), 6'(r + 1));
        fd0 = fd_cnt;
        sf0 = sf_cnt;
        reset = 1'b1;
        tick(1);
        check("rm_data", {31'd0, JOY_DATA}, 32'd1);
        check("rm_cnt", {26'd0, bit_cnt}, 32'd0);
        check("rm_fd", {31'd0, frame_done}, 32'd0);
        check("rm_sf", {31'd0, short_frame}, 32'd0);
        reset = 1'b0;
        tick(1);
        check("rm_post_fd", {31'd0, frame_done}, 32'd0);
        check("rm_post_sf", {31'd0, short_frame}, 32'd0);
        joystick1 = 16'h1234;
        joystick2 = 16'hABCD;
        frm = {~joystick2, ~joystick1};
        do_load(10);
        check("rm_no_sf", sf_cnt - sf0, 0);
        for (int r = 0; r < 32; r++) clock_edge(exp_bit(frm, r + 1), 6'(r + 1));
        check("rm_fd_once", fd_cnt - fd0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/db15_joy_responder.md
# db15_joy_responder

Device-side end of the DB15 serial joystick link: emulates the pair of cascaded parallel-in/serial-out shift registers in a DB15 adapter. It answers host-driven `JOY_LOAD`/`JOY_CLK` with a bit stream on `JOY_DATA` carrying two players' button states. It serves two roles: the loopback model for bench-testing the DB15 reader, and a joystick forwarder through the user port, where the core acts as the adapter for a downstream machine. All logic runs on one clock; the host strobes are asynchronous and are synchronized and glitch-filtered internally.

## Interface
- `BITS`, default 16: bits per player; the frame is 2*BITS bits long.
- `FILTER`, default 2: consecutive identical synchronized samples required before a strobe level is accepted (range 1–8).
- `clk`, in, 1: system clock, 24–50 MHz.
- `reset`, in, 1: synchronous, active-high.
- `joystick1`, in, BITS: player 1 buttons, active-high. Bit 0 = R, 1 = L, 2 = D, 3 = U, 4 upward = buttons.
- `joystick2`, in, BITS: player 2 buttons, same mapping.
- `JOY_LOAD`, in, 1: host parallel-load strobe, active-low, asynchronous.
- `JOY_CLK`, in, 1: host shift clock; shifts on the rising edge; asynchronous.
- `JOY_DATA`, out, 1: serial data, active-low (pressed = 0).
- `bit_cnt`, out, $clog2(2*BITS+1): shifts accepted since the last load.
- `frame_done`, out, 1: one-cycle pulse when `bit_cnt` reaches 2*BITS.
- `short_frame`, out, 1: one-cycle pulse when a load begins with 0 < `bit_cnt` < 2*BITS.

## Operation
- **Input conditioning.** `JOY_LOAD` and `JOY_CLK` each pass through a 2-flop synchronizer, then a filter. The accepted level changes only after FILTER consecutive synchronized samples all differ from the current accepted level. Any disagreeing sample restarts the count.
- **Load (accepted `load_n` = 0).**
  - The 2*BITS shift register reloads every cycle with {~joystick2, ~joystick1}, so the live inputs track continuously.
  - `bit_cnt` is forced to 0.
  - `JOY_DATA` = ~joystick1[0], registered.
- **Freeze.** The snapshot held at the cycle the accepted load rises is the frame content. Input changes after that point do not affect the frame until the next load.
- **Shift.**
  - Trigger: a rising edge of accepted `clk` while accepted `load_n` = 1.
  - The register shifts toward bit 0 and fills with 1 (serial input tied high).
  - `bit_cnt` increments and saturates at 2*BITS.
- **Output order.** Load value first, then one new bit per rising edge: ~joystick1[0..BITS-1], then ~joystick2[0..BITS-1], then constant 1.
- **Frame complete.** `frame_done` pulses in the cycle `bit_cnt` goes from 2*BITS-1 to 2*BITS. Further shifts give no pulse, `bit_cnt` stays at 2*BITS, and `JOY_DATA` stays 1.
- **Load priority.** Accepted `load_n` = 0 dominates. A clock edge accepted in the same cycle as a load, or while load is low, is ignored.
- **Short frame.** `short_frame` pulses in the first cycle accepted `load_n` is 0 if 0 < `bit_cnt` < 2*BITS at that point. `bit_cnt` = 0 or 2*BITS produces no pulse.
- **Edge qualification.** A clock edge is qualified against the previous accepted level only. The rise of `JOY_LOAD` itself never produces a shift.

## Timing
- **Reset values.** Shift register all 1s, `JOY_DATA` = 1, `bit_cnt` = 0, `frame_done` = 0, `short_frame` = 0. Accepted `load_n` = 1, accepted `clk` = 0, filter counters = 0.
- **Reset mid-frame.** Returns to the reset state within one cycle. No pulses are issued in the cycle reset is high or in the following cycle.
- **Latency.** A raw strobe edge, stable thereafter, updates `JOY_DATA`, `bit_cnt` and the pulses 2 + FILTER + 1 cycles later: 5 cycles at the default.
- **Live tracking.** While load is low, a `joystick1[0]` change reaches `JOY_DATA` in 1 cycle.
- **Minimum host timing.** Each `JOY_CLK` high and low phase, and each `JOY_LOAD` low pulse, must last at least FILTER + 2 cycles to be accepted. Shorter pulses are filtered out and are not required to register.
- **Glitch rejection.** A strobe glitch shorter than FILTER cycles, measured after synchronization, causes no shift and no load.

## Test plan
- **Full frame.**
  - Stimulus: joystick1 = 16'h0005, joystick2 = 16'h8000, BITS = 16. Load pulse of 10 cycles, then 32 JOY_CLK periods of 10 high / 10 low.
  - Required: the bit read before each rise is 0,1,0,1,1…1 for player 1; player 2 bits are all 1 except the last, which is 0. `frame_done` pulses exactly once at the 32nd rise; a 33rd rise gives `JOY_DATA` = 1 and `bit_cnt` = 32.
- **Freeze.** Change joystick1 to 16'hFFFF after the load rises, mid-frame. Required: the remaining bits still reflect the snapshot.
- **Short frame.** Load, 7 clocks, load again. Required: `short_frame` pulses once, `bit_cnt` returns to 0, and `JOY_DATA` = ~joystick1[0].
- **Glitch.** With FILTER = 2, JOY_CLK high pulses of 1 and 2 cycles. Required: no shift and `bit_cnt` unchanged. A 4-cycle pulse shifts once.
- **Load priority.** Hold JOY_LOAD low and toggle JOY_CLK 5 times. Required: `bit_cnt` = 0 and `JOY_DATA` tracks live ~joystick1[0].
- **Reset mid-frame.** Assert reset at bit 10. Required: the next cycle shows `JOY_DATA` = 1 and `bit_cnt` = 0 with no pulses. A subsequent load and 32 clocks complete normally.
